// File: rtl/rv_lsu_if.sv
// rtl/rv_lsu_if.sv - EX-stage request/response and DTCM port bundle for rv_lsu
`ifndef MXLEN
`define MXLEN 32
`endif

interface rv_lsu_if #(parameter int DADDR_WID = 30) ();
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic                   req_we_i;
    logic [2:0]             req_funct3_i;
    logic [`MXLEN-1:0]      req_addr_i;
    logic [`MXLEN-1:0]      req_wdata_i;
    logic [4:0]             req_rd_i;
    logic                   resp_valid_o;
    logic [4:0]             resp_rd_o;
    logic [`MXLEN-1:0]      resp_data_o;
    logic                   misalign_o;
    logic [DADDR_WID-1:0]   dtcm_addr_o;
    logic                   dtcm_wr_en_o;
    logic [`MXLEN/8-1:0]    dtcm_wr_strobe_o;
    logic [`MXLEN-1:0]      dtcm_wr_data_o;
    logic                   dtcm_rd_en_o;
    logic [`MXLEN-1:0]      dtcm_rd_data_i;

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        input  dtcm_rd_data_i,
        output req_ready_o, resp_valid_o, resp_rd_o, resp_data_o, misalign_o,
        output dtcm_addr_o, dtcm_wr_en_o, dtcm_wr_strobe_o, dtcm_wr_data_o, dtcm_rd_en_o
    );

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
        output dtcm_rd_data_i,
        input  req_ready_o, resp_valid_o, resp_rd_o, resp_data_o, misalign_o,
        input  dtcm_addr_o, dtcm_wr_en_o, dtcm_wr_strobe_o, dtcm_wr_data_o, dtcm_rd_en_o
    );
endinterface

// File: rtl/rv_lsu.sv
// rtl/rv_lsu.sv - RV32I load/store unit over a 1-cycle DTCM
// RV_LSU_MISALIGN_EN: split word-crossing accesses in two; otherwise raise misalign_o.
`ifndef MXLEN
`define MXLEN 32
`endif

module rv_lsu #(parameter int DADDR_WID = 30) (
    input  logic     clk,
    input  logic     rst_n,
    rv_lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LD_HI, LD_FIN, ST_HI} state_t;
    state_t state, state_nx;

    logic [1:0]           off;
    logic [2:0]           f3;
    logic                 f3_ok, is_h, is_w, mis, accept, go, resp_valid;
    logic [DADDR_WID-1:0] word;
    logic [3:0]           mask;
    logic [7:0]           strb_wide;
    logic [63:0]          wdata_wide, rdata_wide;
    logic [31:0]          rdata_sh, ext;
    logic                 ld_pend;
    logic [4:0]           rd_q;
    logic [2:0]           f3_q;
    logic [1:0]           off_q;
    logic [DADDR_WID-1:0] waddr_q;
    logic [3:0]           st_strb_q;
    logic [31:0]          st_data_q, hold_q;

    assign off    = bus.req_addr_i[1:0];
    assign f3     = bus.req_funct3_i;
    assign word   = bus.req_addr_i[DADDR_WID+1:2];
    assign f3_ok  = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
    assign is_h   = (f3[1:0] == 2'b01);
    assign is_w   = (f3[1:0] == 2'b10);
    assign mis    = (is_h && off == 2'b11) || (is_w && off != 2'b00);
    assign accept = bus.req_valid_i && (state == IDLE);
    assign mask   = is_w ? 4'hF : (is_h ? 4'h3 : 4'h1);
    // Upper halves of the widened lane vectors are the second word of a split store
    assign strb_wide  = {4'b0000, mask} << off;
    assign wdata_wide = {32'b0, bus.req_wdata_i} << {off, 3'b000};

`ifdef RV_LSU_MISALIGN_EN
    localparam bit SPLIT = 1'b1;
    assign bus.misalign_o = 1'b0;
`else
    localparam bit SPLIT = 1'b0;
    logic mis_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mis_q <= 1'b0;
        else        mis_q <= accept && f3_ok && mis;
    end
    assign bus.misalign_o = mis_q;
`endif

    assign go = accept && f3_ok && (!mis || SPLIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go && mis) state_nx = bus.req_we_i ? ST_HI : LD_HI;
            LD_HI:   state_nx = LD_FIN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_o      = (state == IDLE);
        bus.dtcm_addr_o      = '0;
        bus.dtcm_wr_en_o     = 1'b0;
        bus.dtcm_wr_strobe_o = 4'b0000;
        bus.dtcm_wr_data_o   = '0;
        bus.dtcm_rd_en_o     = 1'b0;
        case (state)
            IDLE: if (go) begin
                bus.dtcm_addr_o  = word;
                bus.dtcm_wr_en_o = bus.req_we_i;
                bus.dtcm_rd_en_o = !bus.req_we_i;
                if (bus.req_we_i) begin
                    bus.dtcm_wr_strobe_o = strb_wide[3:0];
                    bus.dtcm_wr_data_o   = wdata_wide[31:0];
                end
            end
            LD_HI: begin
                bus.dtcm_addr_o  = waddr_q;
                bus.dtcm_rd_en_o = 1'b1;
            end
            ST_HI: begin
                bus.dtcm_addr_o      = waddr_q;
                bus.dtcm_wr_en_o     = 1'b1;
                bus.dtcm_wr_strobe_o = st_strb_q;
                bus.dtcm_wr_data_o   = st_data_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_pend   <= 1'b0;
            rd_q      <= '0;
            f3_q      <= '0;
            off_q     <= '0;
            waddr_q   <= '0;
            st_strb_q <= '0;
            st_data_q <= '0;
            hold_q    <= '0;
        end else begin
            ld_pend <= go && !mis && !bus.req_we_i;
            if (go) begin
                rd_q      <= bus.req_rd_i;
                f3_q      <= f3;
                off_q     <= off;
                waddr_q   <= word + {{(DADDR_WID-1){1'b0}}, 1'b1};
                st_strb_q <= strb_wide[7:4];
                st_data_q <= wdata_wide[63:32];
            end
            if (state == LD_HI) hold_q <= bus.dtcm_rd_data_i;
        end
    end

    // A split load sees {second word, first word} as one 8-byte window
    assign resp_valid = ld_pend || (state == LD_FIN);
    assign rdata_wide = (state == LD_FIN) ? {bus.dtcm_rd_data_i, hold_q} : {32'b0, bus.dtcm_rd_data_i};
    assign rdata_sh   = 32'(rdata_wide >> {off_q, 3'b000});

    always_comb begin
        case (f3_q)
            3'b000:  ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001:  ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b100:  ext = {24'b0, rdata_sh[7:0]};
            3'b101:  ext = {16'b0, rdata_sh[15:0]};
            default: ext = rdata_sh;
        endcase
    end

    assign bus.resp_valid_o = resp_valid;
    assign bus.resp_rd_o    = resp_valid ? rd_q : 5'd0;
    assign bus.resp_data_o  = resp_valid ? ext : '0;
endmodule
